// File: rtl/mul_iter.sv
// Iterative signed 32x32 -> 64 multiplier, radix-2 shift-add over 32 cycles.
// Operands are converted to unsigned magnitudes at start acceptance, the
// magnitude product is accumulated one multiplier bit per cycle, and the
// sign is re-applied when the final product is loaded into the result regs.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 sign;

  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       step_upper;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_final;

  // Absolute values of the incoming operands; the most negative value maps
  // to 2^(WIDTH-1), which still fits in an unsigned WIDTH-bit magnitude.
  always_comb begin
    mag1 = src1[WIDTH-1] ? (~src1 + WIDTH'(1)) : src1;
    mag2 = src2[WIDTH-1] ? (~src2 + WIDTH'(1)) : src2;
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half (keeping the carry), then shift the whole accumulator right by one.
  // The final product is this step's result, sign-corrected.
  always_comb begin
    add_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    step_upper = mplier[0] ? add_sum : {1'b0, acc[2*WIDTH-1:WIDTH]};
    acc_step   = {step_upper, acc[WIDTH-1:1]};
    prod_final = sign ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
  end

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      sign      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // flush only aborts CALC, so a simultaneous start is still taken
          if (start) begin
            mcand  <= mag1;
            mplier <= mag2;
            sign   <= src1[WIDTH-1] ^ src2[WIDTH-1];
            acc    <= '0;
            count  <= '0;
            state  <= CALC;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end else begin
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end

        CALC: begin
          if (flush) begin
            // abandon the operation; result registers keep the last product
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            acc    <= acc_step;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (count == LAST_ITER) begin
              result    <= prod_final[WIDTH-1:0];
              result_hi <= prod_final[2*WIDTH-1:WIDTH];
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          // single-cycle completion pulse; start is not looked at here
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Zero flag follows the registered low result word.
  assign zero = (result == '0);

endmodule

// File: tb/tb_mul_iter.sv
// Directed + random bench for mul_iter with an expected-product scoreboard.
module tb_mul_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;

  int          tests;
  int          fails;
  int          cyc;
  int          acc_cyc;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  mul_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .src1      (src1),
    .src2      (src2),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic with_flush);
    chk("ready_before_start", 64'(ready), 64'd1);
    src1  = a;
    src2  = b;
    start = 1'b1;
    flush = with_flush;
    tick();
    start = 1'b0;
    flush = 1'b0;
    acc_cyc = cyc;
    exp_q.push_back(model(a, b));
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("ready_after_accept", 64'(ready), 64'd0);
    $display("[TB] issue src1=0x%08h src2=0x%08h", a, b);
  endtask

  task automatic wait_done(input string tag, input logic flush_in_done);
    logic [63:0] e;
    int          lat;
    while (!done && (cyc - acc_cyc) < 100) tick();
    lat = cyc - acc_cyc;
    chk({tag, "_latency"}, 64'(lat), 64'd32);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
    if (done) begin
      chk({tag, "_lo"}, 64'(result), 64'(e[31:0]));
      chk({tag, "_hi"}, 64'(result_hi), 64'(e[63:32]));
      chk({tag, "_zero"}, 64'(zero), 64'(e[31:0] == 32'd0));
      chk({tag, "_ready_in_done"}, 64'(ready), 64'd0);
      $display("[TB] done %s result_hi=0x%08h result=0x%08h latency=%0d", tag, result_hi, result, lat);
    end
    last_exp = e;
    flush = flush_in_done;
    tick();
    flush = 1'b0;
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_ready_after"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int dcount;
    logic [31:0] ra;
    logic [31:0] rb;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    acc_cyc  = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    src1     = '0;
    src2     = '0;

    // reset values
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_result_hi", 64'(result_hi), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    tick();

    // basic products, including the most-negative-squared boundary
    issue(32'd7, 32'd6, 1'b0);
    wait_done("mul_7x6", 1'b0);
    chk("mul_7x6_const", {result_hi, result}, 64'h0000_0000_0000_002A);
    issue(32'hFFFF_FFFD, 32'd5, 1'b0);
    wait_done("mul_m3x5", 1'b0);
    chk("mul_m3x5_const", {result_hi, result}, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done("mul_min_sq", 1'b0);
    chk("mul_min_sq_const", {result_hi, result}, 64'h4000_0000_0000_0000);
    chk("mul_min_sq_zero", 64'(zero), 64'd1);

    // second start mid-CALC is ignored
    issue(32'd1000, 32'hFFFF_FF00, 1'b0);
    repeat (4) tick();
    src1  = 32'd3;
    src2  = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignore_start_ready", 64'(ready), 64'd0);
    chk("ignore_start_busy", 64'(busy), 64'd1);
    wait_done("ignore_start", 1'b0);

    // flush at cycle 10 of CALC: no done, result retained
    issue(32'd100, 32'd200, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    void'(exp_q.pop_back());
    dcount = 0;
    repeat (40) begin
      tick();
      if (done) dcount++;
    end
    chk("flush_no_done", 64'(dcount), 64'd0);
    chk("flush_result_kept", {result_hi, result}, last_exp);
    issue(32'd2, 32'd3, 1'b0);
    wait_done("after_flush_2x3", 1'b0);
    chk("after_flush_2x3_const", {result_hi, result}, 64'd6);

    // start together with flush in IDLE is accepted; flush in DONE is harmless
    issue(32'hFFFF_FFF9, 32'hFFFF_FFF8, 1'b1);
    wait_done("start_with_flush", 1'b1);

    // asynchronous reset at cycle 20 of CALC
    issue(32'd12345, 32'hFFFF_FFF9, 1'b0);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", {result_hi, result}, 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", 64'(done), 64'd0);
    issue(32'd1, 32'd1, 1'b0);
    wait_done("after_rst_1x1", 1'b0);
    chk("after_rst_1x1_const", {result_hi, result}, 64'd1);

    // random operands, issued back-to-back where possible
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 32'd0;
      issue(ra, rb, 1'b0);
      wait_done("random", 1'b0);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result word width; only 32 is verified.
REQ-002 SHALL provide: clk  input  1  single clock, rising-edge.
REQ-003 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide: start  input  1  request; accepted only when ready=1.
REQ-005 SHALL provide: flush  input  1  synchronous abort of an in-flight operation.
REQ-006 SHALL provide: src1  input  32  signed two's-complement multiplicand.
REQ-007 SHALL provide: src2  input  32  signed two's-complement multiplier.
REQ-008 SHALL provide: ready  output  1  high in IDLE only.
REQ-009 SHALL provide: busy  output  1  high in CALC only.
REQ-010 SHALL provide: done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide: result  output  32  low word of the signed 64-bit product; drives the execute-stage result path for ALU_control=8 (multiply).
REQ-012 SHALL provide: result_hi  output  32  high word of the signed 64-bit product.
REQ-013 SHALL provide: zero  output  1  high when result (low word) == 0.

Function
REQ-014 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-015 SHALL, in IDLE with start=1 at edge E0, latch |src1| and |src2| as 32-bit unsigned magnitudes, latch sign = src1[31]^src2[31], clear the 64-bit accumulator and the 5-bit counter, and enter CALC.
REQ-016 SHALL ignore start in CALC and DONE; no queuing, and latched operands are not disturbed.
REQ-017 SHALL, in CALC, perform one radix-2 shift-add iteration per edge: if the multiplier LSB is 1, add the multiplicand into the accumulator upper half, then shift right by one.
REQ-018 SHALL, on the 32nd CALC edge (counter==31, edge E32), load {result_hi,result} with the accumulator, negated as 64 bits when sign=1, and enter DONE.
REQ-019 SHALL assert done for exactly one cycle (between E32 and E33) and return to IDLE at E33; latency start-accept to done-high is 32 cycles; back-to-back issue is possible at E33.
REQ-020 SHALL hold result, result_hi and zero stable from E32 until the next product load; they do not change at start acceptance.
REQ-021 SHALL treat 0x80000000 as magnitude 2^31 (fits the 32-bit unsigned magnitude); no overflow is possible and no overflow output exists.
REQ-022 SHALL, when flush=1 at an edge in CALC, return to IDLE at that edge without asserting done and without updating result/result_hi/zero.
REQ-023 SHALL give flush no effect in IDLE; in DONE, the state still returns to IDLE and done is not extended.
REQ-024 SHALL, when start and flush are both 1 in IDLE, accept start (flush applies to CALC only).
REQ-025 SHALL compute zero combinationally from the registered result.

Reset
REQ-026 SHALL, on rst_n=0 at any time (including mid-CALC), asynchronously force state=IDLE, counter=0, accumulator=0, result=0, result_hi=0, done=0, busy=0.
REQ-027 SHALL, during reset, drive ready=1 and zero=1.
REQ-028 SHALL resume normal operation at the first rising edge after rst_n deasserts; there is no residual done pulse.

Verification
REQ-029 SHALL cover: src1=7, src2=6, start pulse -> done high exactly 32 cycles after acceptance; result=0x0000002A, result_hi=0, zero=0.
REQ-030 SHALL cover: src1=-3 (0xFFFFFFFD), src2=5 -> result=0xFFFFFFF1, result_hi=0xFFFFFFFF.
REQ-031 SHALL cover: src1=src2=0x80000000 -> result=0, result_hi=0x40000000, zero=1.
REQ-032 SHALL cover: a second start with different operands at cycle 5 of CALC -> ignored; first product returned unchanged; ready stays 0 until E33.
REQ-033 SHALL cover: flush at cycle 10 of CALC -> IDLE next cycle, no done, result keeps its prior value; a following 2*3 yields 6.
REQ-034 SHALL cover: rst_n low at cycle 20 of CALC -> all outputs at reset values immediately; after release, 1*1 -> result=1 after 32 cycles.
